// File: rtl/stack_if.sv
// Command/response handshake between a stack client and stack_ctrl.
// The master issues push/pop and consumes popped words; the slave is the stack engine.
interface stack_if #(
  parameter int WIDTH = 16
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d_push;
  logic             cmd_ready;
  logic [WIDTH-1:0] d_pop;
  logic             pop_valid;
  logic             pop_ready;

  modport master (
    output push, pop, d_push, pop_ready,
    input  cmd_ready, d_pop, pop_valid
  );

  modport slave (
    input  push, pop, d_push, pop_ready,
    output cmd_ready, d_pop, pop_valid
  );
endinterface

// File: rtl/stack_ctrl.sv
// LIFO stack engine driving an external register file. It owns the stack
// pointer, full/empty tracking and error detection; storage lives in the register file.
//
//  state | meaning
//  IDLE  | cmd_ready=1, sample push/pop
//  WRITE | one-cycle register-file write at address count, then count+1
//  READ  | register-file read at address count-1, capture word, count-1
//  RESP  | pop_valid=1, hold d_pop until pop_ready
module stack_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  stack_if.slave           bus,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             err,
  output logic             rf_wr,
  output logic [AW-1:0]    rf_wr_addr,
  output logic [WIDTH-1:0] rf_d_in,
  output logic [AW-1:0]    rf_rd_addr,
  input  logic [WIDTH-1:0] rf_d_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [1:0]       state;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] d_pop_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;

  // Status and register-file port decoded from registered state.
  // The read address is top-of-stack (count-1 mod DEPTH); it only matters in READ.
  always_comb begin
    full          = (count_q == CNT_FULL);
    empty         = (count_q == '0);
    count         = count_q;
    err           = err_q;
    bus.cmd_ready = (state == IDLE);
    bus.pop_valid = (state == RESP);
    bus.d_pop     = d_pop_q;
    rf_wr         = (state == WRITE);
    rf_wr_addr    = count_q[AW-1:0];
    rf_d_in       = data_q;
    rf_rd_addr    = count_q[AW-1:0] - ADDR_ONE;
  end

  // Command FSM, stack pointer, popped-word register and error pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      count_q <= '0;
      d_pop_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.push && bus.pop) begin
            err_q <= 1'b1;
          end else if (bus.push) begin
            if (full) begin
              err_q <= 1'b1;
            end else begin
              data_q <= bus.d_push;
              state  <= WRITE;
            end
          end else if (bus.pop) begin
            if (empty) err_q <= 1'b1;
            else       state <= READ;
          end
        end
        WRITE: begin
          count_q <= count_q + CNT_ONE;
          state   <= IDLE;
        end
        READ: begin
          d_pop_q <= rf_d_out;
          count_q <= count_q - CNT_ONE;
          state   <= RESP;
        end
        RESP: begin
          if (bus.pop_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural 8x16 register file.
module tb_stack_ctrl;
  logic        clk;
  logic        reset;
  logic        full, empty, err;
  logic [3:0]  count;
  logic        rf_wr;
  logic [2:0]  rf_wr_addr, rf_rd_addr;
  logic [15:0] rf_d_in, rf_d_out;
  logic [15:0] rf_mem [8];

  int total = 0;
  int bad   = 0;

  stack_if #(.WIDTH(16)) bus ();

  stack_ctrl #(.WIDTH(16), .DEPTH(8), .AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .err       (err),
    .rf_wr     (rf_wr),
    .rf_wr_addr(rf_wr_addr),
    .rf_d_in   (rf_d_in),
    .rf_rd_addr(rf_rd_addr),
    .rf_d_out  (rf_d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file: synchronous write, combinational read
  always @(posedge clk) if (rf_wr) rf_mem[rf_wr_addr] <= rf_d_in;
  assign rf_d_out = rf_mem[rf_rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) chk("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
  endtask

  // push one word and check the write cycle and resulting count
  task automatic do_push(input logic [15:0] d, input int exp_cnt_before);
    wait_ready();
    bus.push = 1'b1;
    bus.d_push = d;
    tick();
    bus.push = 1'b0;
    chk("push_rf_wr", 32'(rf_wr), 32'd1);
    chk("push_addr", 32'(rf_wr_addr), 32'(exp_cnt_before));
    chk("push_data", 32'(rf_d_in), 32'(d));
    tick();
    chk("push_count", 32'(count), 32'(exp_cnt_before + 1));
    chk("push_rdy", 32'(bus.cmd_ready), 32'd1);
  endtask

  // pop one word with pop_ready=1 and check read address and data
  task automatic do_pop(input logic [15:0] exp_d, input int exp_cnt_before);
    wait_ready();
    bus.pop = 1'b1;
    bus.pop_ready = 1'b1;
    tick();
    bus.pop = 1'b0;
    chk("pop_rd_addr", 32'(rf_rd_addr), 32'(exp_cnt_before - 1));
    chk("pop_rf_wr", 32'(rf_wr), 32'd0);
    tick();
    chk("pop_valid", 32'(bus.pop_valid), 32'd1);
    chk("pop_data", 32'(bus.d_pop), 32'(exp_d));
    tick();
    chk("pop_count", 32'(count), 32'(exp_cnt_before - 1));
    chk("pop_idle", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.d_push = '0;
    bus.pop_ready = 1'b0;
    reset = 1'b0;

    // 1: reset
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rf_wr", 32'(rf_wr), 32'd0);
    chk("rst_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dpop", 32'(bus.d_pop), 32'd0);
    reset = 1'b1;
    tick();

    // 2: fill, then overflow
    for (int i = 0; i < 8; i++) do_push(16'(16'h1111 * (i + 1)), i);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);
    bus.push = 1'b1;
    bus.d_push = 16'h9999;
    tick();
    bus.push = 1'b0;
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_rf_wr", 32'(rf_wr), 32'd0);
    chk("ovf_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    chk("ovf_err_clr", 32'(err), 32'd0);
    chk("ovf_count", 32'(count), 32'd8);

    // 3: drain, then underflow
    for (int i = 0; i < 8; i++) do_pop(16'(16'h1111 * (8 - i)), 8 - i);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    chk("udf_err", 32'(err), 32'd1);
    chk("udf_valid", 32'(bus.pop_valid), 32'd0);
    tick();
    chk("udf_err_clr", 32'(err), 32'd0);
    chk("udf_valid2", 32'(bus.pop_valid), 32'd0);

    // 4: backpressured response, push ignored while busy
    do_push(16'hA5A5, 0);
    bus.pop_ready = 1'b0;
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(bus.pop_valid), 32'd1);
      chk("hold_data", 32'(bus.d_pop), 32'hA5A5);
      chk("hold_ready", 32'(bus.cmd_ready), 32'd0);
      if (i == 1) begin
        bus.push = 1'b1;
        bus.d_push = 16'h0001;
      end else begin
        bus.push = 1'b0;
      end
      tick();
      chk("hold_err", 32'(err), 32'd0);
      chk("hold_rf_wr", 32'(rf_wr), 32'd0);
    end
    bus.push = 1'b0;
    bus.pop_ready = 1'b1;
    tick();
    chk("rel_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rel_valid", 32'(bus.pop_valid), 32'd0);
    chk("rel_count", 32'(count), 32'd0);

    // 5: push and pop together
    do_push(16'h0101, 0);
    do_push(16'h0202, 1);
    do_push(16'h0303, 2);
    bus.push = 1'b1;
    bus.pop = 1'b1;
    bus.d_push = 16'h0404;
    tick();
    bus.push = 1'b0;
    bus.pop = 1'b0;
    chk("both_err", 32'(err), 32'd1);
    chk("both_rf_wr", 32'(rf_wr), 32'd0);
    chk("both_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    chk("both_count", 32'(count), 32'd3);
    chk("both_err_clr", 32'(err), 32'd0);
    do_pop(16'h0303, 3);

    // 6: reset during WRITE
    bus.push = 1'b1;
    bus.d_push = 16'h7777;
    tick();
    bus.push = 1'b0;
    chk("mid_rf_wr", 32'(rf_wr), 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_rf_wr_off", 32'(rf_wr), 32'd0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_empty", 32'(empty), 32'd1);
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
